pc_next_gen: RTL and testbench

//   Program-counter register and next-PC generator for the single-cycle MIPS core; drives the

---
 rtl/pc_next_gen_pkg.sv | 20 ++
 rtl/pc_next_gen_if.sv | 29 ++
 rtl/pc_next_gen_irq_sync_edge.sv | 29 ++
 rtl/pc_next_gen.sv | 87 ++++++++
 tb/tb_pc_next_gen.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_next_gen_pkg.sv
// Shared encodings and default vectors for the program-counter block and its neighbours.
package pc_next_gen_pkg;

  localparam logic [2:0] PC_SRC_SEQ    = 3'd0;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd1;
  localparam logic [2:0] PC_SRC_JUMP   = 3'd2;
  localparam logic [2:0] PC_SRC_JR     = 3'd3;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC_DEF  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;

  localparam logic [4:0] KREG_K0 = 5'd26;

  // Address arithmetic lives in bits [30:0]; the supervisor bit rides along untouched.
  function automatic logic [31:0] pc_add(input logic [31:0] base, input logic [30:0] inc);
    return {base[31], base[30:0] + inc};
  endfunction

endpackage

// File: rtl/pc_next_gen_if.sv
// Control/address bundle between the decode/execute logic (master) and the PC generator (slave).
interface pc_next_gen_if;

  logic        stall;
  logic [2:0]  pc_src;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic [31:0] jr_addr;
  logic        irq;
  logic        undef_instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        supervisor;
  logic        epc_we;
  logic [31:0] epc_wdata;
  logic        irq_ack;

  modport master (
    output stall, pc_src, branch_taken, imm16, jtarget, jr_addr, irq, undef_instr,
    input  pc, pc_plus4, supervisor, epc_we, epc_wdata, irq_ack
  );

  modport slave (
    input  stall, pc_src, branch_taken, imm16, jtarget, jr_addr, irq, undef_instr,
    output pc, pc_plus4, supervisor, epc_we, epc_wdata, irq_ack
  );

endinterface

// File: rtl/pc_next_gen_irq_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level input followed by a rising-edge pulse.
module irq_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  // The extra top flop holds the previous synchronised level for edge detection.
  logic [STAGES:0] chain_q;
  logic [STAGES:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-1:0], async_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign rise = chain_q[STAGES-1] & ~chain_q[STAGES];

endmodule

// File: rtl/pc_next_gen.sv
// PC register and next-PC selection with reset/interrupt/exception vectoring and EPC write.
module pc_next_gen
  import pc_next_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [31:0] IRQ_VEC     = IRQ_VEC_DEF,
  parameter logic [31:0] EXC_VEC     = EXC_VEC_DEF,
  parameter int          SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset,
  pc_next_gen_if.slave  bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        irq_pend_q;
  logic        irq_pend_d;
  logic        irq_rise;
  logic        take_exc;
  logic        take_irq;
  logic [31:0] pc_plus4;
  logic [30:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] jr_tgt;

  irq_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk      (clk),
    .rst      (reset),
    .async_in (bus.irq),
    .rise     (irq_rise)
  );

  always_comb begin
    pc_plus4 = pc_add(pc_q, 31'd4);
    br_off   = {{13{bus.imm16[15]}}, bus.imm16, 2'b00};
    br_tgt   = pc_add(pc_plus4, br_off);
    jmp_tgt  = {pc_q[31:28], bus.jtarget, 2'b00};
    // jr may drop to user mode but can never raise privilege.
    jr_tgt   = {bus.jr_addr[31] & pc_q[31], bus.jr_addr[30:0]};
  end

  always_comb begin
    take_exc = ~reset & bus.undef_instr & ~bus.stall;
    take_irq = ~reset & irq_pend_q & ~pc_q[31] & ~bus.stall & ~take_exc;

    pc_d = pc_plus4;
    if (bus.stall) begin
      pc_d = pc_q;
    end else if (take_exc) begin
      pc_d = EXC_VEC;
    end else if (take_irq) begin
      pc_d = IRQ_VEC;
    end else begin
      case (bus.pc_src)
        PC_SRC_BRANCH: pc_d = bus.branch_taken ? br_tgt : pc_plus4;
        PC_SRC_JUMP:   pc_d = jmp_tgt;
        PC_SRC_JR:     pc_d = jr_tgt;
        default:       pc_d = pc_plus4;
      endcase
    end

    // A fresh edge arriving as the old request is taken counts as a new request.
    irq_pend_d = (irq_pend_q & ~take_irq) | irq_rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      irq_pend_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.supervisor = pc_q[31];
  assign bus.epc_we     = take_exc | take_irq;
  assign bus.epc_wdata  = take_exc ? pc_plus4 : pc_q;
  assign bus.irq_ack    = take_irq;

endmodule

// File: tb/tb_pc_next_gen.sv
// Directed scenarios followed by randomized traffic, all checked against a behavioural PC model.
module tb_pc_next_gen;
  import pc_next_gen_pkg::*;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_next_gen_if bus ();

  pc_next_gen #(
    .RESET_PC    (RESET_PC_DEF),
    .IRQ_VEC     (IRQ_VEC_DEF),
    .EXC_VEC     (EXC_VEC_DEF),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // stimulus for the next cycle
  logic        s_rst, s_st, s_bt, s_irq, s_un;
  logic [2:0]  s_src;
  logic [15:0] s_imm;
  logic [25:0] s_jt;
  logic [31:0] s_ja;

  // reference model state
  logic [31:0] m_pc;
  bit          m_pend;
  bit          irq_hist[$];

  // observations captured just before each edge
  logic        last_we, last_ack;
  logic [31:0] last_wdata;
  int          ack_cnt;
  int          npass, nchk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clr();
    s_rst = 0; s_st = 0; s_bt = 0; s_un = 0;
    s_src = PC_SRC_SEQ; s_imm = '0; s_jt = '0; s_ja = '0;
  endtask

  task automatic step();
    logic [31:0] p4, nxt;
    logic        exc, take, rise;
    int          off;
    @(negedge clk);
    reset = s_rst;
    bus.stall = s_st; bus.pc_src = s_src; bus.branch_taken = s_bt; bus.imm16 = s_imm;
    bus.jtarget = s_jt; bus.jr_addr = s_ja; bus.irq = s_irq; bus.undef_instr = s_un;
    #1;
    p4   = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
    exc  = !s_rst && s_un && !s_st;
    take = !s_rst && m_pend && !m_pc[31] && !s_st && !exc;
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, p4);
    chk("supervisor", {31'd0, bus.supervisor}, {31'd0, m_pc[31]});
    chk("epc_we", {31'd0, bus.epc_we}, {31'd0, exc || take});
    chk("irq_ack", {31'd0, bus.irq_ack}, {31'd0, take});
    if (exc || take) chk("epc_wdata", bus.epc_wdata, exc ? p4 : m_pc);
    last_we = bus.epc_we; last_ack = bus.irq_ack; last_wdata = bus.epc_wdata;
    if (bus.irq_ack) ack_cnt++;

    if (s_rst) nxt = RESET_PC_DEF;
    else if (s_st) nxt = m_pc;
    else if (exc) nxt = EXC_VEC_DEF;
    else if (take) nxt = IRQ_VEC_DEF;
    else begin
      case (s_src)
        3'd1: begin
          off = int'($signed(s_imm)) * 4;
          nxt = s_bt ? ((m_pc & 32'h8000_0000) | ((p4 + 32'(off)) & 32'h7FFF_FFFF)) : p4;
        end
        3'd2: nxt = (m_pc & 32'hF000_0000) | (32'(s_jt) * 4);
        3'd3: nxt = s_ja & (m_pc[31] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF);
        default: nxt = p4;
      endcase
    end
    rise = irq_hist[SYNC-1] && !irq_hist[SYNC];

    @(posedge clk);
    m_pc = nxt;
    if (s_rst) begin
      m_pend = 0;
      for (int i = 0; i <= SYNC; i++) irq_hist[i] = 0;
    end else begin
      m_pend = (m_pend && !take) || rise;
      irq_hist.push_front(s_irq);
      void'(irq_hist.pop_back());
    end
    #1;
  endtask

  initial begin
    int n;
    npass = 0; nchk = 0; ack_cnt = 0;
    m_pc = 32'hX; m_pend = 0;
    for (int i = 0; i <= SYNC; i++) irq_hist.push_back(0);
    clr(); s_irq = 0;

    // reset, with an undefined instruction flagged to prove reset wins
    s_rst = 1; s_un = 1;
    @(negedge clk); reset = 1; @(posedge clk); #1;
    m_pc = RESET_PC_DEF;
    step(); step();
    chk("rst_pc", bus.pc, 32'h8000_0000);
    chk("rst_epc_we", {31'd0, last_we}, 32'd0);
    chk("rst_irq_ack", {31'd0, last_ack}, 32'd0);

    clr();
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", bus.pc, 32'h8000_0000 + 32'(4 * i));
      step();
      chk("seq_epc_we", {31'd0, last_we}, 32'd0);
    end

    // jump, then jr dropping and not raising supervisor
    s_src = PC_SRC_JUMP; s_jt = 26'h11; step();
    chk("jump", bus.pc, 32'h8000_0044);
    s_src = PC_SRC_JR; s_ja = 32'h0000_0068; step();
    chk("jr_user", bus.pc, 32'h0000_0068);
    chk("jr_sup_clear", {31'd0, bus.supervisor}, 32'd0);
    s_ja = 32'h8000_0100; step();
    chk("jr_no_raise", bus.pc, 32'h0000_0100);

    // branches
    s_ja = 32'h40; step();
    s_src = PC_SRC_BRANCH; s_bt = 1; s_imm = 16'hFFFC; step();
    chk("br_taken", bus.pc, 32'h0000_0034);
    s_src = PC_SRC_JR; s_ja = 32'h40; step();
    s_src = PC_SRC_BRANCH; s_bt = 0; step();
    chk("br_not_taken", bus.pc, 32'h0000_0044);

    // interrupt from user code
    s_src = PC_SRC_JR; s_ja = 32'h70; step();
    clr(); ack_cnt = 0;
    s_irq = 1; step(); s_irq = 0; n = 1;
    while (bus.pc !== IRQ_VEC_DEF && n < SYNC + 4) begin step(); n++; end
    chk("irq_entry_pc", bus.pc, IRQ_VEC_DEF);
    chk("irq_latency", {31'd0, n <= SYNC + 2}, 32'd1);
    chk("irq_epc", last_wdata, 32'h70 + 32'(4 * (SYNC + 1)));
    step(); step();
    chk("irq_ack_once", 32'(ack_cnt), 32'd1);

    // second request while in supervisor: held until user mode, then taken once
    ack_cnt = 0;
    s_irq = 1; step(); s_irq = 0;
    for (int i = 0; i < 6; i++) step();
    chk("irq_masked", 32'(ack_cnt), 32'd0);
    s_src = PC_SRC_JR; s_ja = 32'h70; step(); clr();
    for (int i = 0; i < 4; i++) step();
    chk("irq_after_return", 32'(ack_cnt), 32'd1);

    // exception beats pending interrupt; stall suppresses both
    s_irq = 1; step(); s_irq = 0;
    for (int i = 0; i < 4; i++) step();
    s_src = PC_SRC_JR; s_ja = 32'h50; step(); clr();
    s_un = 1; s_st = 1; step();
    chk("stall_hold", bus.pc, 32'h0000_0050);
    chk("stall_no_we", {31'd0, last_we}, 32'd0);
    s_st = 0; step();
    chk("exc_we", {31'd0, last_we}, 32'd1);
    chk("exc_epc", last_wdata, 32'h0000_0054);
    chk("exc_no_ack", {31'd0, last_ack}, 32'd0);
    chk("exc_pc", bus.pc, 32'h8000_0008);

    // reset while the pending interrupt is about to be taken
    clr(); s_src = PC_SRC_JR; s_ja = 32'h60; step();
    clr(); ack_cnt = 0; s_rst = 1; step();
    chk("rst_mid_ack", {31'd0, last_ack}, 32'd0);
    chk("rst_mid_pc", bus.pc, 32'h8000_0000);
    clr(); s_src = PC_SRC_JR; s_ja = 32'h60; step(); clr();
    for (int i = 0; i < 4; i++) step();
    chk("rst_clears_pend", 32'(ack_cnt), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      s_rst = ($urandom_range(63) == 0);
      s_st  = ($urandom_range(4) == 0);
      s_un  = ($urandom_range(11) == 0);
      s_src = 3'($urandom_range(7));
      s_bt  = 1'($urandom_range(1));
      s_imm = 16'($urandom);
      s_jt  = 26'($urandom);
      s_ja  = $urandom;
      if ($urandom_range(5) == 0) s_irq = ~s_irq;
      step();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
